// File: rtl/hazard_scoreboard.sv
// Per-register write scoreboard for an NSTAGE in-order pipeline: detects issue
// hazards at D and drives per-stage stall/flush for hazards, freeze and exceptions.
module hazard_scoreboard #(
    parameter  int NSTAGE    = 5,
    parameter  int NREG      = 32,
    parameter  int RA_W      = 5,
    parameter  int EXC_STAGE = 3,
    parameter  int CNT_W     = 32,
    localparam int SW        = $clog2(NSTAGE)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              d_valid,
    input  logic [RA_W-1:0]   d_rs,
    input  logic [RA_W-1:0]   d_rt,
    input  logic              d_rs_used,
    input  logic              d_rt_used,
    input  logic              d_wen,
    input  logic [RA_W-1:0]   d_waddr,
    input  logic [SW-1:0]     d_rdy_stage,
    input  logic              d_long,
    input  logic              lu_done,
    input  logic [RA_W-1:0]   lu_waddr,
    input  logic              freeze,
    input  logic              exc_flush,
    output logic [NSTAGE-1:0] stall,
    output logic [NSTAGE-1:0] flush,
    output logic              d_issue,
    output logic [CNT_W-1:0]  hz_cycles
);

    localparam logic [NSTAGE-1:0] EXC_MASK = NSTAGE'((64'd1 << (EXC_STAGE + 1)) - 64'd1);
    localparam logic [SW-1:0]     LAST_STG = SW'(NSTAGE - 1);
    localparam logic [SW-1:0]     EXC_STG  = SW'(EXC_STAGE);
    localparam logic [SW-1:0]     ISSUE_STG = SW'(2);

    logic          pend   [NREG];
    logic          long_q [NREG];
    logic [SW-1:0] stg    [NREG];
    logic [SW-1:0] rdy    [NREG];

    logic hz;
    logic issue_wr;

    function automatic logic src_hazard(input logic [RA_W-1:0] a, input logic used);
        return used && (a != '0) && pend[a] && (long_q[a] || (stg[a] < rdy[a]));
    endfunction

    always_comb begin
        hz = d_valid && (src_hazard(d_rs, d_rs_used) || src_hazard(d_rt, d_rt_used) ||
                         (d_wen && (d_waddr != '0) && pend[d_waddr] && long_q[d_waddr]));
    end

    // Outputs are gated by resetn so an asserted reset silences them immediately.
    always_comb begin
        stall   = '0;
        flush   = '0;
        d_issue = 1'b0;
        if (!resetn) begin
            stall = '0;
        end else if (freeze) begin
            stall = '1;
        end else if (exc_flush) begin
            flush = EXC_MASK;
        end else if (hz) begin
            stall[1:0] = 2'b11;
            flush[2]   = 1'b1;
        end else begin
            d_issue = d_valid;
        end
    end

    assign issue_wr = d_issue && d_wen && (d_waddr != '0);

    // NOTE: the entry arrays are reset explicitly; pend must start clear, and
    // the other fields are small enough that resetting them costs nothing.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < NREG; r++) begin
                pend[r]   <= 1'b0;
                long_q[r] <= 1'b0;
                stg[r]    <= '0;
                rdy[r]    <= '0;
            end
            hz_cycles <= '0;
        end else begin
            // Later assignments win: advance, then lu_done, then a new issue.
            for (int r = 1; r < NREG; r++) begin
                if (!freeze && pend[r] && !long_q[r]) begin
                    if ((exc_flush && (stg[r] <= EXC_STG)) || (stg[r] == LAST_STG)) begin
                        pend[r] <= 1'b0;
                    end else begin
                        stg[r] <= stg[r] + SW'(1);
                    end
                end
                if (lu_done && (lu_waddr == RA_W'(r)) && pend[r] && long_q[r]) begin
                    pend[r] <= 1'b0;
                end
                if (issue_wr && (d_waddr == RA_W'(r))) begin
                    pend[r]   <= 1'b1;
                    long_q[r] <= d_long;
                    stg[r]    <= ISSUE_STG;
                    rdy[r]    <= d_rdy_stage;
                end
            end
            if (!freeze && !exc_flush && hz && (hz_cycles != '1)) begin
                hz_cycles <= hz_cycles + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (NSTAGE=5, EXC_STAGE=3, 4-bit counter so
// saturation is reachable).
module tb_hazard_scoreboard;

    localparam int NSTAGE = 5;
    localparam int CNT_W  = 4;

    logic             clk = 1'b0;
    logic             resetn;
    logic             d_valid, d_rs_used, d_rt_used, d_wen, d_long, lu_done, freeze, exc_flush;
    logic [4:0]       d_rs, d_rt, d_waddr, lu_waddr;
    logic [2:0]       d_rdy_stage;
    logic [4:0]       stall, flush;
    logic             d_issue;
    logic [CNT_W-1:0] hz_cycles;

    int checks = 0;
    int errors = 0;
    logic [CNT_W-1:0] exp_hz = '0;

    hazard_scoreboard #(.NSTAGE(NSTAGE), .NREG(32), .RA_W(5), .EXC_STAGE(3), .CNT_W(CNT_W)) dut (
        .clk(clk), .resetn(resetn), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
        .d_rs_used(d_rs_used), .d_rt_used(d_rt_used), .d_wen(d_wen), .d_waddr(d_waddr),
        .d_rdy_stage(d_rdy_stage), .d_long(d_long), .lu_done(lu_done), .lu_waddr(lu_waddr),
        .freeze(freeze), .exc_flush(exc_flush), .stall(stall), .flush(flush),
        .d_issue(d_issue), .hz_cycles(hz_cycles)
    );

    always #5 clk = ~clk;

    task automatic idle();
        d_valid = 0; d_rs = 0; d_rt = 0; d_rs_used = 0; d_rt_used = 0;
        d_wen = 0; d_waddr = 0; d_rdy_stage = 0; d_long = 0;
        lu_done = 0; lu_waddr = 0; freeze = 0; exc_flush = 0;
    endtask

    task automatic issue_write(input logic [4:0] wa, input logic [2:0] rdy, input logic lng);
        idle();
        d_valid = 1; d_wen = 1; d_waddr = wa; d_rdy_stage = rdy; d_long = lng;
    endtask

    task automatic read_regs(input logic [4:0] rs, input logic rs_u, input logic [4:0] rt, input logic rt_u);
        idle();
        d_valid = 1; d_rs = rs; d_rs_used = rs_u; d_rt = rt; d_rt_used = rt_u;
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // Expected {stall, flush, d_issue} patterns.
    localparam logic [10:0] OUT_ISSUE  = {5'b00000, 5'b00000, 1'b1};
    localparam logic [10:0] OUT_HAZARD = {5'b00011, 5'b00100, 1'b0};
    localparam logic [10:0] OUT_FREEZE = {5'b11111, 5'b00000, 1'b0};
    localparam logic [10:0] OUT_EXC    = {5'b00000, 5'b01111, 1'b0};
    localparam logic [10:0] OUT_QUIET  = {5'b00000, 5'b00000, 1'b0};

    task automatic test_reset();
        idle();
        resetn = 0;
        freeze = 1; exc_flush = 1;
        #12;
        checks++;
        if ({stall, flush, d_issue} !== OUT_QUIET) begin
            errors++;
            $display("FAIL reset_outputs got %b expected %b", {stall, flush, d_issue}, OUT_QUIET);
        end
        checks++;
        if (hz_cycles !== '0) begin
            errors++;
            $display("FAIL reset_hz got %0d expected 0", hz_cycles);
        end
        idle();
        resetn = 1;
        tick();
        read_regs(5'd3, 1, 5'd4, 1);
        settle();
        checks++;
        if ({stall, flush, d_issue} !== OUT_ISSUE) begin
            errors++;
            $display("FAIL reset_empty_issue got %b expected %b", {stall, flush, d_issue}, OUT_ISSUE);
        end
        tick();
    endtask

    task automatic test_load_use();
        issue_write(5'd5, 3'd3, 0);
        settle();
        checks++;
        if (d_issue !== 1'b1) begin
            errors++;
            $display("FAIL load_issue got %b expected 1", d_issue);
        end
        tick();
        read_regs(5'd5, 1, 5'd0, 0);
        settle();
        checks++;
        if ({stall, flush, d_issue} !== OUT_HAZARD) begin
            errors++;
            $display("FAIL load_use_hazard got %b expected %b", {stall, flush, d_issue}, OUT_HAZARD);
        end
        tick();
        exp_hz = exp_hz + 1'b1;
        checks++;
        if (hz_cycles !== exp_hz) begin
            errors++;
            $display("FAIL load_use_hz got %0d expected %0d", hz_cycles, exp_hz);
        end
        settle();
        checks++;
        if ({stall, flush, d_issue} !== OUT_ISSUE) begin
            errors++;
            $display("FAIL load_use_release got %b expected %b", {stall, flush, d_issue}, OUT_ISSUE);
        end
        tick();
        idle();
        tick(); tick();
    endtask

    task automatic test_alu_forward();
        issue_write(5'd7, 3'd2, 0);
        settle();
        checks++;
        if (d_issue !== 1'b1) begin
            errors++;
            $display("FAIL alu_write_issue got %b expected 1", d_issue);
        end
        tick();
        issue_write(5'd8, 3'd2, 0);
        d_rt = 5'd7; d_rt_used = 1;
        settle();
        checks++;
        if ({stall, flush, d_issue} !== OUT_ISSUE) begin
            errors++;
            $display("FAIL alu_dep1 got %b expected %b", {stall, flush, d_issue}, OUT_ISSUE);
        end
        tick();
        read_regs(5'd8, 1, 5'd7, 1);
        settle();
        checks++;
        if ({stall, flush, d_issue} !== OUT_ISSUE) begin
            errors++;
            $display("FAIL alu_dep2 got %b expected %b", {stall, flush, d_issue}, OUT_ISSUE);
        end
        tick();
        checks++;
        if (hz_cycles !== exp_hz) begin
            errors++;
            $display("FAIL alu_hz got %0d expected %0d", hz_cycles, exp_hz);
        end
        idle();
        tick(); tick(); tick();
    endtask

    task automatic test_long_latency();
        issue_write(5'd9, 3'd0, 1);
        tick();
        for (int i = 0; i < 2; i++) begin
            read_regs(5'd9, 1, 5'd0, 0);
            settle();
            checks++;
            if ({stall, flush, d_issue} !== OUT_HAZARD) begin
                errors++;
                $display("FAIL long_raw_stall%0d got %b expected %b", i, {stall, flush, d_issue}, OUT_HAZARD);
            end
            tick();
            exp_hz = exp_hz + 1'b1;
        end
        issue_write(5'd9, 3'd2, 0);
        settle();
        checks++;
        if ({stall, flush, d_issue} !== OUT_HAZARD) begin
            errors++;
            $display("FAIL long_waw_stall got %b expected %b", {stall, flush, d_issue}, OUT_HAZARD);
        end
        tick();
        exp_hz = exp_hz + 1'b1;
        read_regs(5'd0, 0, 5'd9, 1);
        lu_done = 1; lu_waddr = 5'd9;
        settle();
        checks++;
        if ({stall, flush, d_issue} !== OUT_HAZARD) begin
            errors++;
            $display("FAIL long_done_same_cycle got %b expected %b", {stall, flush, d_issue}, OUT_HAZARD);
        end
        tick();
        exp_hz = exp_hz + 1'b1;
        read_regs(5'd0, 0, 5'd9, 1);
        settle();
        checks++;
        if ({stall, flush, d_issue} !== OUT_ISSUE) begin
            errors++;
            $display("FAIL long_after_done got %b expected %b", {stall, flush, d_issue}, OUT_ISSUE);
        end
        checks++;
        if (hz_cycles !== exp_hz) begin
            errors++;
            $display("FAIL long_hz got %0d expected %0d", hz_cycles, exp_hz);
        end
        tick();
        idle();
    endtask

    task automatic test_exc_flush();
        // r10 long; r1, r2, r3 end up at stg 4, 3, 2 with a never-forwardable rdy.
        issue_write(5'd10, 3'd0, 1); tick();
        issue_write(5'd1, 3'd7, 0);  tick();
        issue_write(5'd2, 3'd7, 0);  tick();
        issue_write(5'd3, 3'd7, 0);  tick();
        idle();
        d_valid = 1; exc_flush = 1;
        settle();
        checks++;
        if ({stall, flush, d_issue} !== OUT_EXC) begin
            errors++;
            $display("FAIL exc_flush_vec got %b expected %b", {stall, flush, d_issue}, OUT_EXC);
        end
        tick();
        read_regs(5'd2, 1, 5'd3, 1);
        settle();
        checks++;
        if ({stall, flush, d_issue} !== OUT_ISSUE) begin
            errors++;
            $display("FAIL exc_cleared got %b expected %b", {stall, flush, d_issue}, OUT_ISSUE);
        end
        tick();
        read_regs(5'd1, 1, 5'd10, 1);
        settle();
        checks++;
        if ({stall, flush, d_issue} !== OUT_HAZARD) begin
            errors++;
            $display("FAIL exc_long_survives got %b expected %b", {stall, flush, d_issue}, OUT_HAZARD);
        end
        tick();
        exp_hz = exp_hz + 1'b1;
        idle();
        lu_done = 1; lu_waddr = 5'd10;
        tick();
        idle();
    endtask

    task automatic test_freeze();
        issue_write(5'd11, 3'd0, 1); tick();
        issue_write(5'd12, 3'd3, 0); tick();
        read_regs(5'd11, 1, 5'd0, 0);
        freeze = 1;
        settle();
        checks++;
        if ({stall, flush, d_issue} !== OUT_FREEZE) begin
            errors++;
            $display("FAIL freeze_vec got %b expected %b", {stall, flush, d_issue}, OUT_FREEZE);
        end
        tick();
        lu_done = 1; lu_waddr = 5'd11;
        tick();
        checks++;
        if (hz_cycles !== exp_hz) begin
            errors++;
            $display("FAIL freeze_hz got %0d expected %0d", hz_cycles, exp_hz);
        end
        read_regs(5'd11, 1, 5'd12, 1);
        settle();
        checks++;
        if ({stall, flush, d_issue} !== OUT_HAZARD) begin
            errors++;
            $display("FAIL freeze_held_entry got %b expected %b", {stall, flush, d_issue}, OUT_HAZARD);
        end
        tick();
        exp_hz = exp_hz + 1'b1;
        settle();
        checks++;
        if ({stall, flush, d_issue} !== OUT_ISSUE) begin
            errors++;
            $display("FAIL freeze_lu_cleared got %b expected %b", {stall, flush, d_issue}, OUT_ISSUE);
        end
        tick();
        idle();
        tick(); tick();
    endtask

    task automatic test_r0_and_saturation();
        issue_write(5'd0, 3'd3, 1); tick();
        read_regs(5'd0, 1, 5'd0, 1);
        settle();
        checks++;
        if ({stall, flush, d_issue} !== OUT_ISSUE) begin
            errors++;
            $display("FAIL r0_no_hazard got %b expected %b", {stall, flush, d_issue}, OUT_ISSUE);
        end
        tick();
        issue_write(5'd13, 3'd0, 1); tick();
        for (int i = 0; i < 18; i++) begin
            read_regs(5'd13, 1, 5'd0, 0);
            tick();
            exp_hz = (exp_hz == '1) ? exp_hz : exp_hz + 1'b1;
            checks++;
            if (hz_cycles !== exp_hz) begin
                errors++;
                $display("FAIL sat_hz%0d got %0d expected %0d", i, hz_cycles, exp_hz);
            end
        end
        checks++;
        if (hz_cycles !== 4'hF) begin
            errors++;
            $display("FAIL sat_final got %0d expected 15", hz_cycles);
        end
        idle();
        lu_done = 1; lu_waddr = 5'd13;
        tick();
        idle();
    endtask

    task automatic test_reset_mid();
        issue_write(5'd14, 3'd0, 1); tick();
        read_regs(5'd14, 1, 5'd0, 0);
        freeze = 1;
        #2 resetn = 0;
        #1;
        checks++;
        if ({stall, flush, d_issue} !== OUT_QUIET) begin
            errors++;
            $display("FAIL mid_reset_outputs got %b expected %b", {stall, flush, d_issue}, OUT_QUIET);
        end
        checks++;
        if (hz_cycles !== '0) begin
            errors++;
            $display("FAIL mid_reset_hz got %0d expected 0", hz_cycles);
        end
        tick();
        resetn = 1;
        read_regs(5'd14, 1, 5'd0, 0);
        tick();
        read_regs(5'd14, 1, 5'd0, 0);
        settle();
        checks++;
        if ({stall, flush, d_issue} !== OUT_ISSUE) begin
            errors++;
            $display("FAIL mid_reset_cleared got %b expected %b", {stall, flush, d_issue}, OUT_ISSUE);
        end
        tick();
    endtask

    initial begin
        idle();
        resetn = 0;
        test_reset();
        test_load_use();
        test_alu_forward();
        test_long_latency();
        test_exc_flush();
        test_freeze();
        test_r0_and_saturation();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the fixed 5-stage hazard unit: a per-register scoreboard for an NSTAGE in-order pipeline.
- Tracks every in-flight register write by its current stage, its ready stage, and whether it comes from a long-latency unit (divider, CP0).
- Drives per-stage stall/flush vectors for issue hazards, external freeze (imem/dmem busy) and exception flush.
- Also counts hazard stall cycles for the performance counters.

Parameters:
- NSTAGE, 5, pipeline depth; stage 0 = F, stage 1 = D (issue), stage NSTAGE-1 = W.
- NREG, 32, architectural registers; register 0 is never tracked.
- RA_W, 5, register address width, equal to clog2(NREG).
- EXC_STAGE, 3, stage that raises exceptions/eret; must satisfy 2 <= EXC_STAGE < NSTAGE.
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- d_valid  in  1  D holds a valid instruction
- d_rs, d_rt  in  RA_W  D source registers
- d_rs_used, d_rt_used  in  1  corresponding source is actually read
- d_wen  in  1  D instruction writes a register
- d_waddr  in  RA_W  destination register
- d_rdy_stage  in  clog2(NSTAGE)  first stage whose result is forwardable (e.g. 2 for ALU, 3 for load)
- d_long  in  1  destination is written by a long-latency unit
- lu_done  in  1  long-latency unit writes back this cycle
- lu_waddr  in  RA_W  register written by lu_done
- freeze  in  1  external freeze (imem or dmem busy)
- exc_flush  in  1  exception or eret taken at EXC_STAGE
- stall  out  NSTAGE  per-stage hold
- flush  out  NSTAGE  per-stage bubble insert
- d_issue  out  1  D instruction advances this cycle
- hz_cycles  out  CNT_W  saturating count of hazard stall cycles

Behaviour:
- Per-register state: pend, long, stg[clog2(NSTAGE)], rdy[clog2(NSTAGE)]. All pend bits are 0 after reset.
- Outputs on reset: stall = 0, flush = 0, hz_cycles = 0. d_issue is combinational from the current inputs.
- Source hazard, for a source X with X_used=1 and X != 0:
  - pend[X] and long[X] → hazard.
  - pend[X] and !long[X] and stg[X] < rdy[X] → hazard.
- WAW hazard: d_wen, d_waddr != 0, pend[d_waddr] and long[d_waddr].
- hz = d_valid & (any source hazard | WAW hazard).
- Combinational priority, highest first:
  1. freeze: stall = all 1, flush = 0, d_issue = 0. The scoreboard holds its state, except that lu_done is still applied.
  2. exc_flush: stall = 0; flush bits 0..EXC_STAGE = 1, upper bits = 0; d_issue = 0. Clear every non-long entry with stg <= EXC_STAGE. Surviving entries advance.
  3. hz: stall bits 0 and 1 = 1; flush bit 2 = 1; all other bits 0; d_issue = 0. Entries advance. hz_cycles increments, saturating at all-ones.
  4. Otherwise: stall = 0, flush = 0, d_issue = d_valid.
- Advance rule (whenever not frozen):
  - Every pending non-long entry: stg++.
  - An entry at stg = NSTAGE-1 clears pend instead of advancing.
  - Long entries keep pend until a matching lu_done; their stg is ignored.
- On d_issue with d_wen and d_waddr != 0, write the entry in the same edge: pend = 1, long = d_long, stg = 2, rdy = d_rdy_stage.
  - This overrides any older non-long entry for the same register; the youngest writer wins.
- lu_done with lu_waddr != 0 clears a long entry for that register. It is ignored if the entry is non-long or not pending.
- A new issue to the same register in the same cycle as lu_done takes precedence.
- If lu_done clears the register that D is reading in the same cycle, there is still a hazard that cycle; the instruction issues next cycle.
- Register 0 never sets pend and never produces a hazard.
- Asserting resetn low mid-operation immediately clears all entries and outputs.

Test Plan:
- Load r5 (rdy=3) issues; the next D reads r5 → exactly 1 hazard cycle: stall = 00011, flush = 00100, hz_cycles = 1; then d_issue = 1.
- ALU write of r7 (rdy=2) followed by a dependent instruction → no stall, d_issue = 1 in consecutive cycles.
- Divider write of r9 (d_long=1), then a reader of r9 → stalled until lu_done with lu_waddr = 9; issue follows in the next cycle. A WAW write to r9 is also stalled.
- exc_flush with entries at stg 2, 3 and 4 → flush = 01111 (EXC_STAGE = 3). The stg 2 and stg 3 entries are cleared; the stg 4 entry retires normally. Long entries survive.
- freeze asserted with a hazard present → stall = 11111, flush = 0, hz_cycles unchanged, entries hold. An lu_done during the freeze still clears its entry.
- Reader of r0 with d_rs_used = 1 → no hazard. hz_cycles at all-ones plus one more hazard cycle → stays at all-ones.
